// File: rtl/bicubic_pkg.sv
// Shared constants, request-FSM encoding and edge-clamp helper for the bicubic window feeder.
package bicubic_pkg;
  localparam int CHANNEL_WIDTH  = 8;
  localparam int WIN_DIM        = 4;
  localparam int TAP_OFS        = 1;
  localparam int NUM_PHASES     = 4;
  localparam int RSP_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } req_state_e;

  // Edge replication: out-of-range coordinates snap to the nearest valid pixel.
  function automatic int clamp_idx(input int v, input int hi);
    if (v < 0) begin
      return 0;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction
endpackage

// File: rtl/bicubic_rsp_fifo.sv
// Two-entry result FIFO between the upsampler response port and the output stream.
module bicubic_rsp_fifo
  import bicubic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [RSP_FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == 2'(RSP_FIFO_DEPTH));
  assign empty = (cnt_q == 2'd0);
  assign rdata = mem_q[rd_ptr_q];

  // Pointer and occupancy update; push is refused while full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/bicubic_window_feeder.sv
// Buffers four source rows and issues clamped 4x4 windows (four phases per pixel) to a bicubic
// upsampler, then streams its results out with per-frame last/done framing.
`ifndef SRC_IMG_WIDTH
`define SRC_IMG_WIDTH 4
`endif
`ifndef SRC_IMG_HEIGHT
`define SRC_IMG_HEIGHT 4
`endif
module bicubic_window_feeder
  import bicubic_pkg::*;
#(
  parameter int SRC_W         = `SRC_IMG_WIDTH,
  parameter int SRC_H         = `SRC_IMG_HEIGHT,
  parameter int CHANNEL_WIDTH = bicubic_pkg::CHANNEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNEL_WIDTH-1:0]   in_data,
  output logic                       bf_req_valid,
  input  logic                       bcci_req_ready,
  output logic [CHANNEL_WIDTH-1:0]   p1, p2, p3, p4, p5, p6, p7, p8,
  output logic [CHANNEL_WIDTH-1:0]   p9, p10, p11, p12, p13, p14, p15, p16,
  input  logic                       bcci_rsp_valid,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
  output logic                       bf_rsp_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*CHANNEL_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       frame_done
);
  localparam int XW       = $clog2(SRC_W);
  localparam int YW       = $clog2(SRC_H + 2);
  localparam int N_BEATS  = NUM_PHASES * SRC_W * SRC_H;
  localparam int BW       = $clog2(N_BEATS);
  localparam int LAST_COL = SRC_W - 1;
  localparam int LAST_ROW = SRC_H - 1;

  req_state_e               state_q, state_d;
  logic [XW-1:0]            col_q, col_d, x_q, x_d;
  logic [YW-1:0]            fill_row_q, fill_row_d, y_q, y_d;
  logic [1:0]               phase_q, phase_d;
  logic                     row_loaded_q, row_loaded_d, req_valid_q, req_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [CHANNEL_WIDTH-1:0] p_q [16];
  logic [CHANNEL_WIDTH-1:0] p_d [16];
  logic [CHANNEL_WIDTH-1:0] window_pix [16];
  logic [CHANNEL_WIDTH-1:0] lb_q [4][SRC_W];
  logic                     lb_we, issue_ok, row_end, fifo_full, fifo_empty, out_pop;

  assign issue_ok = (state_q == ST_RUN) && (!req_valid_q || bcci_req_ready);
  assign row_end  = issue_ok && row_loaded_q && req_valid_q;

  // Line-buffer write port; row y lands in slot y mod 4.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[fill_row_q[1:0]][col_q] <= in_data;
    end
  end

  // Gather the clamped 4x4 neighbourhood around (x_q, y_q).
  always_comb begin
    int yy;
    int xx;
    yy = 0;
    xx = 0;
    for (int r = 0; r < WIN_DIM; r++) begin
      for (int c = 0; c < WIN_DIM; c++) begin
        yy = clamp_idx(int'(y_q) - TAP_OFS + r, LAST_ROW);
        xx = clamp_idx(int'(x_q) - TAP_OFS + c, LAST_COL);
        window_pix[WIN_DIM*r + c] = lb_q[yy[1:0]][XW'(xx)];
      end
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Request FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (lb_we && (int'(col_q) == LAST_COL) && (int'(fill_row_q) >= int'(y_q) + 2)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (!row_end) begin
          state_d = ST_RUN;
        end else if (int'(y_q) == LAST_ROW) begin
          state_d = ST_WAIT;
        end else if (int'(fill_row_q) <= LAST_ROW) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (frame_done_q) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Request FSM outputs.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_FILL:         in_ready = 1'b1;
      ST_RUN, ST_WAIT: in_ready = 1'b0;
      default:         in_ready = 1'b0;
    endcase
    lb_we = in_ready & in_valid;
  end

  // Fill/issue counters and the window holding register.
  always_comb begin
    col_d        = col_q;
    fill_row_d   = fill_row_q;
    y_d          = y_q;
    x_d          = x_q;
    phase_d      = phase_q;
    row_loaded_d = row_loaded_q;
    req_valid_d  = req_valid_q;
    p_d          = p_q;
    if (lb_we) begin
      if (int'(col_q) == LAST_COL) begin
        col_d      = {XW{1'b0}};
        fill_row_d = fill_row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end else if (issue_ok && !row_loaded_q) begin
      p_d         = window_pix;
      req_valid_d = 1'b1;
      if (int'(x_q) == LAST_COL) begin
        x_d = {XW{1'b0}};
        if (phase_q == 2'd3) begin
          phase_d      = 2'd0;
          row_loaded_d = 1'b1;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end else if (issue_ok) begin
      // Last window of the row just left; the FSM picks FILL, RUN or WAIT.
      req_valid_d = 1'b0;
      if (row_end) begin
        row_loaded_d = 1'b0;
        y_d          = (int'(y_q) == LAST_ROW) ? y_q : y_q + YW'(1);
      end else begin
        row_loaded_d = row_loaded_q;
      end
    end else if ((state_q == ST_WAIT) && frame_done_q) begin
      fill_row_d = {YW{1'b0}};
      col_d      = {XW{1'b0}};
      y_d        = {YW{1'b0}};
    end else begin
      req_valid_d = req_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= {XW{1'b0}};
      fill_row_q   <= {YW{1'b0}};
      y_q          <= {YW{1'b0}};
      x_q          <= {XW{1'b0}};
      phase_q      <= 2'd0;
      row_loaded_q <= 1'b0;
      req_valid_q  <= 1'b0;
      for (int i = 0; i < 16; i++) p_q[i] <= {CHANNEL_WIDTH{1'b0}};
    end else begin
      col_q        <= col_d;
      fill_row_q   <= fill_row_d;
      y_q          <= y_d;
      x_q          <= x_d;
      phase_q      <= phase_d;
      row_loaded_q <= row_loaded_d;
      req_valid_q  <= req_valid_d;
      p_q          <= p_d;
    end
  end

  assign bf_req_valid = req_valid_q;
  assign {p1, p2, p3, p4}     = {p_q[0],  p_q[1],  p_q[2],  p_q[3]};
  assign {p5, p6, p7, p8}     = {p_q[4],  p_q[5],  p_q[6],  p_q[7]};
  assign {p9, p10, p11, p12}  = {p_q[8],  p_q[9],  p_q[10], p_q[11]};
  assign {p13, p14, p15, p16} = {p_q[12], p_q[13], p_q[14], p_q[15]};

  bicubic_rsp_fifo #(.WIDTH(4*CHANNEL_WIDTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bcci_rsp_valid),
    .pop   (out_pop),
    .wdata ({bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1}),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bf_rsp_ready = !fifo_full;
  assign out_valid    = !fifo_empty;
  assign out_pop      = out_valid && out_ready;
  assign out_last     = out_valid && (beat_q == BW'(N_BEATS - 1));
  assign frame_done   = frame_done_q;

  // Beat counter wraps once per frame; frame_done follows the last beat by one cycle.
  always_comb begin
    beat_d       = beat_q;
    frame_done_d = out_pop && out_last;
    if (out_pop) begin
      beat_d = out_last ? {BW{1'b0}} : beat_q + BW'(1);
    end else begin
      beat_d = beat_q;
    end
  end

  // Output framing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q       <= {BW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_bicubic_window_feeder.sv
// Directed bench: 4x4 frame of pixels 16*y+x, echoing responder, output stall, mid-frame reset.
module tb_bicubic_window_feeder;
  localparam int W = 4;
  localparam int H = 4;
  localparam int CW = 8;
  localparam int NB = 4 * W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, bf_req_valid, bcci_req_ready, bcci_rsp_valid, bf_rsp_ready;
  logic          out_valid, out_ready, out_last, frame_done;
  logic [CW-1:0] in_data;
  logic [CW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16;
  logic [CW-1:0] d1, d2, d3, d4;
  logic [4*CW-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int pix, win, beat;
  bit frame_seen, hold_done;
  int q[$];

  always #5 clk = ~clk;

  bicubic_window_feeder #(.SRC_W(W), .SRC_H(H), .CHANNEL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .p9(p9), .p10(p10), .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p15(p15), .p16(p16),
    .bcci_rsp_valid(bcci_rsp_valid), .bcci_rsp_data1(d1), .bcci_rsp_data2(d2),
    .bcci_rsp_data3(d3), .bcci_rsp_data4(d4), .bf_rsp_ready(bf_rsp_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [CW-1:0] nv;
    in_valid       = (pix < W * H);
    in_data        = CW'((pix / W) * 16 + (pix % W));
    bcci_rsp_valid = (q.size() > 0);
    nv             = (q.size() > 0) ? CW'(q[0]) : 8'h00;
    {d4, d3, d2, d1} = {nv, nv, nv, nv};
  endtask

  // One clock: sample handshakes before the edge, update the model after it.
  task automatic cycle();
    logic ih, rh, sh, oh, lst;
    logic [63:0] wa, wb;
    logic [31:0] od;
    logic [7:0]  b8;
    ih  = in_valid & in_ready;
    rh  = bf_req_valid & bcci_req_ready;
    sh  = bcci_rsp_valid & bf_rsp_ready;
    oh  = out_valid & out_ready;
    lst = out_last;
    od  = out_data;
    wa  = {p1, p2, p3, p4, p5, p6, p7, p8};
    wb  = {p9, p10, p11, p12, p13, p14, p15, p16};
    if (bf_req_valid) chk("in_ready_low_in_run", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("frame_done", 64'(frame_done), 64'(oh & lst));
    if (ih) begin
      if (pix == 12) chk("windows_before_row3_fill", 64'(win), 64'd16);
      pix++;
    end
    if (rh) begin
      if (win == 0) begin
        chk("first_win_rows01", wa, 64'h0000_0102_0000_0102);
        chk("first_win_rows23", wb, 64'h1010_1112_2020_2122);
      end
      if (win == 17) begin
        chk("mid_win_rows01", wa, 64'h0001_0203_1011_1213);
        chk("mid_win_rows23", wb, 64'h2021_2223_3031_3233);
      end
      if (win == 63) begin
        chk("last_win_rows01", wa, 64'h2223_2323_3233_3333);
        chk("last_win_rows23", wb, 64'h3233_3333_3233_3333);
      end
      win++;
      q.push_back(win);
    end
    if (sh) void'(q.pop_front());
    if (oh) begin
      beat++;
      b8 = 8'(beat);
      chk("out_data", 64'(od), 64'({b8, b8, b8, b8}));
      chk("out_last", 64'(lst), 64'(beat == NB));
      if (lst) begin
        chk("windows_per_frame", 64'(win), 64'(NB));
        frame_seen = 1'b1;
        win = 0;
        beat = 0;
        pix = 0;
      end
    end
    drive();
  endtask

  task automatic run_frame();
    frame_seen = 1'b0;
    for (int c = 0; c < 3000 && !frame_seen; c++) begin
      if (!hold_done && beat == 5) begin
        out_ready = 1'b0;
        repeat (10) cycle();
        chk("rsp_ready_low_when_full", 64'(bf_rsp_ready), 64'd0);
        chk("out_valid_held", 64'(out_valid), 64'd1);
        chk("out_data_held", 64'(out_data), 64'h0606_0606);
        out_ready = 1'b1;
        hold_done = 1'b1;
      end
      cycle();
    end
    chk("frame_completed", 64'(frame_seen), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    bcci_req_ready = 1'b1;
    bcci_rsp_valid = 1'b0;
    {d4, d3, d2, d1} = 32'h0;
    out_ready = 1'b1;
    pix = 0;
    win = 0;
    beat = 0;
    hold_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bf_req_valid", 64'(bf_req_valid), 64'd0);
    chk("rst_bf_rsp_ready", 64'(bf_rsp_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_p1_p8", {p1, p2, p3, p4, p5, p6, p7, p8}, 64'd0);
    chk("rst_p9_p16", {p9, p10, p11, p12, p13, p14, p15, p16}, 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    drive();
    run_frame();

    // Second frame is cut short by reset while issuing row 1, column 2.
    for (int c = 0; c < 3000 && win != 18; c++) cycle();
    chk("reached_y1_x2", 64'(win), 64'd18);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_bf_req_valid", 64'(bf_req_valid), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_bf_rsp_ready", 64'(bf_rsp_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    pix = 0;
    win = 0;
    beat = 0;
    drive();
    run_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
